// File: rtl/ci_frame_writer.sv
// ci_frame_writer
//   Multicycle custom-instruction slave that fills the one-bit-per-pixel
//   frame RAM read by the display stage. A WRITE turns one 32-bit pixel
//   word into 32 single-bit RAM writes at consecutive addresses, starting
//   at the base address carried in dataa. An optional CLEAR fills the
//   whole frame with one bit value.
//
//   Build option: define FRAME_CLEAR_EN to include the CLEAR opcode. When
//   it is not defined, opcode 01 is treated as reserved and answers with
//   the error result.
//
// Ports
//   clk      in   system clock, shared with the RAM write port
//   reset    in   synchronous active-high reset
//   start    in   instruction start pulse (accepted only in IDLE)
//   dataa    in   [31:30] opcode, [ADDR_W-1:0] base pixel address
//   datab    in   WRITE: pixel bits, bit 0 first; CLEAR: fill value in bit 0
//   done     out  one-cycle completion pulse
//   result   out  completion value, held until the next completion
//   wr_data  out  pixel bit for the RAM
//   wr_addr  out  RAM write address
//   wr_en    out  RAM write enable
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; operands captured when start is seen
// S_WRITE  | one pixel bit per cycle, base+k, 32 beats
// S_CLEAR  | fill value to every address 0..2**ADDR_W-1 (FRAME_CLEAR_EN)
// S_FINISH | done pulse, result updated, no RAM writes
module ci_frame_writer #(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       dataa,
  input  logic [31:0]       datab,
  output logic              done,
  output logic [31:0]       result,
  output logic              wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en
);

  localparam int IDX_W = $clog2(WORD_W);
`ifdef FRAME_CLEAR_EN
  // Wide enough to reach the full frame depth as a terminal count.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(2 ** ADDR_W);
`else
  localparam int CNT_W = IDX_W + 1;
`endif
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_CLEAR  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [WORD_W-1:0]   pix_q, pix_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [31:0]         result_q, result_d;
  logic                wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                wr_en_q, wr_en_d;

  // Address bits above the frame depth carry no meaning.
  logic unused_dataa;
  assign unused_dataa = ^dataa[29:ADDR_W];

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    pix_d     = pix_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    result_d  = result_q;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    wr_en_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = dataa[ADDR_W-1:0];
          pix_d  = datab;
          case (dataa[31:30])
            2'b00: begin
              // Beat 0 is issued straight from the operands so the first
              // write lands in the cycle right after start.
              state_d   = S_WRITE;
              wr_en_d   = 1'b1;
              wr_addr_d = dataa[ADDR_W-1:0];
              wr_data_d = datab[0];
              cnt_d     = CNT_W'(1);
            end
`ifdef FRAME_CLEAR_EN
            2'b01: begin
              state_d   = S_CLEAR;
              wr_en_d   = 1'b1;
              wr_addr_d = '0;
              wr_data_d = datab[0];
              cnt_d     = CNT_W'(1);
            end
`endif
            default: begin
              state_d  = S_FINISH;
              done_d   = 1'b1;
              result_d = 32'hFFFF_FFFF;
            end
          endcase
        end
      end

      S_WRITE: begin
        if (cnt_q == WORD_LAST) begin
          state_d  = S_FINISH;
          done_d   = 1'b1;
          result_d = {{(32-ADDR_W){1'b0}}, base_q + ADDR_W'(WORD_W)};
          cnt_d    = '0;
        end else begin
          // Address wraps naturally in ADDR_W bits.
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + ADDR_W'(cnt_q);
          wr_data_d = pix_q[cnt_q[IDX_W-1:0]];
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end

`ifdef FRAME_CLEAR_EN
      S_CLEAR: begin
        if (cnt_q == FRAME_LAST) begin
          state_d  = S_FINISH;
          done_d   = 1'b1;
          result_d = 32'(2 ** ADDR_W);
          cnt_d    = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = pix_q[0];
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
`endif

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      pix_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      wr_data_q <= 1'b0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      pix_q     <= pix_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      result_q  <= result_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
    end
  end

  assign done    = done_q;
  assign result  = result_q;
  assign wr_data = wr_data_q;
  assign wr_addr = wr_addr_q;
  assign wr_en   = wr_en_q;

endmodule

// File: tb/tb_ci_frame_writer.sv
module tb_ci_frame_writer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        done;
  logic [31:0] result;
  logic        wr_data;
  logic [11:0] wr_addr;
  logic        wr_en;

  int checks = 0;
  int errors = 0;

  ci_frame_writer #(.ADDR_W(12), .WORD_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dataa   (dataa),
    .datab   (datab),
    .done    (done),
    .result  (result),
    .wr_data (wr_data),
    .wr_addr (wr_addr),
    .wr_en   (wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    int          restart_cyc;   // cycle in which a second start is driven (0 = none)
    int          reset_cyc;     // cycle in which reset is driven (0 = none)
    int          window;        // cycles observed after start
    int          exp_writes;
    int          exp_done_cyc;  // 0 = no done expected
    logic [31:0] exp_result;    // value of result at the end of the window
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          n_wr;
    int          n_done;
    int          done_cyc;
    int          bad_content;
    int          bad_stable;
    int          bad_overlap;
    logic [31:0] res_at_done;
    logic [31:0] prev_res;
    logic [11:0] ea;
    logic        ed;
    n_wr = 0; n_done = 0; done_cyc = 0; bad_content = 0;
    bad_stable = 0; bad_overlap = 0; res_at_done = '0;

    @(negedge clk);
    prev_res = result;
    start = 1'b1;
    dataa = v.a;
    datab = v.b;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Operands must have been captured at start.
    dataa = ~v.a;
    datab = ~v.b;

    for (int cyc = 1; cyc <= v.window; cyc++) begin
      @(negedge clk);
      if (wr_en) begin
`ifdef FRAME_CLEAR_EN
        if (v.a[31:30] == 2'b01) begin
          ea = 12'(n_wr);
          ed = v.b[0];
        end else begin
          ea = v.a[11:0] + 12'(n_wr);
          ed = v.b[n_wr % 32];
        end
`else
        ea = v.a[11:0] + 12'(n_wr);
        ed = v.b[n_wr % 32];
`endif
        if (wr_addr !== ea || wr_data !== ed) begin
          if (bad_content < 3)
            $display("  beat %0d addr=0x%03h data=%b, model addr=0x%03h data=%b",
                     n_wr, wr_addr, wr_data, ea, ed);
          bad_content++;
        end
        n_wr++;
      end
      if (done) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc    = cyc;
          res_at_done = result;
        end
        if (wr_en) bad_overlap++;
      end else if (v.reset_cyc == 0 && result !== prev_res) begin
        bad_stable++;
      end
      prev_res = result;
      start = (cyc == v.restart_cyc);
      if (cyc == v.restart_cyc) begin
        dataa = 32'hC000_0123;
        datab = 32'h5555_AAAA;
      end
      reset = (cyc == v.reset_cyc);
    end
    start = 1'b0;
    reset = 1'b0;

    check({v.name, " n_writes"},     32'(n_wr),        32'(v.exp_writes));
    check({v.name, " n_done"},       32'(n_done),      (v.exp_done_cyc != 0) ? 32'd1 : 32'd0);
    check({v.name, " done_cycle"},   32'(done_cyc),    32'(v.exp_done_cyc));
    check({v.name, " write_content"},32'(bad_content), 32'd0);
    check({v.name, " done_wr_en"},   32'(bad_overlap), 32'd0);
    check({v.name, " result_stable"},32'(bad_stable),  32'd0);
    if (v.exp_done_cyc != 0)
      check({v.name, " result_at_done"}, res_at_done, v.exp_result);
    check({v.name, " result_held"},  result,           v.exp_result);
  endtask

  initial begin
    vecs[0] = '{"write_40",      32'h0000_0040, 32'hA5A5_0F0F, 0,  0,  40,   32, 33, 32'h0000_0060};
    vecs[1] = '{"write_wrap",    32'h0000_0FF0, 32'hFFFF_FFFF, 0,  0,  40,   32, 33, 32'h0000_0010};
`ifdef FRAME_CLEAR_EN
    vecs[2] = '{"clear",         32'h4000_0123, 32'h0000_0001, 0,  0,  4105, 4096, 4097, 32'h0000_1000};
`else
    vecs[2] = '{"clear_absent",  32'h4000_0123, 32'h0000_0001, 0,  0,  8,    0,  1,  32'hFFFF_FFFF};
`endif
    vecs[3] = '{"op11",          32'hC000_0000, 32'h1234_5678, 0,  0,  8,    0,  1,  32'hFFFF_FFFF};
    vecs[4] = '{"op10",          32'h8000_0555, 32'hFFFF_FFFF, 0,  0,  8,    0,  1,  32'hFFFF_FFFF};
    vecs[5] = '{"restart_c10",   32'h0000_0123, 32'h0000_0001, 10, 0,  40,   32, 33, 32'h0000_0143};
    vecs[6] = '{"reset_c15",     32'h0000_07E5, 32'h1234_5678, 0,  15, 40,   15, 0,  32'h0000_0000};
    vecs[7] = '{"after_reset",   32'h0000_0000, 32'hDEAD_BEEF, 0,  0,  40,   32, 33, 32'h0000_0020};
    vecs[8] = '{"start_on_done", 32'h0000_0FFF, 32'h8000_0001, 33, 0,  40,   32, 33, 32'h0000_001F};

    reset = 1'b1;
    start = 1'b0;
    dataa = '0;
    datab = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle after reset: everything quiet and result cleared.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", {done, wr_en, wr_data, 17'd0, wr_addr}, 32'd0);
      check("idle_result", result, 32'd0);
    end

    for (int i = 0; i < 9; i++)
      run_vec(vecs[i]);

    // Reset in the middle of an idle period leaves result at zero.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_clears_result", result, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ci_frame_writer.md
# ci_frame_writer

Nios II multicycle custom-instruction slave that fills the 64×64 one-bit-per-pixel frame RAM read by the VGA display stage. It accepts one 32-bit pixel word per instruction and serialises it into 32 single-bit RAM writes at consecutive addresses. It drives the RAM write port (`wr_data`/`wr_addr`/`wr_en`) and the custom-instruction handshake (`done`/`result`). It sits directly upstream of the frame RAM, which the display stage reads.

## Interface
- `ADDR_W`, 12: frame RAM address width; depth is 2**ADDR_W pixels (4096 = 64×64).
- `WORD_W`, 32: pixel bits per instruction; equals `datab` width.

- `clk`  in  1  system clock; the RAM write port is clocked by the same clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  custom-instruction start; single-cycle pulse.
- `dataa`  in  32  `[31:30]` opcode (00 WRITE, 01 CLEAR, 10/11 reserved); `[ADDR_W-1:0]` base pixel address.
- `datab`  in  32  WRITE: pixel bits, bit 0 first. CLEAR: fill value in bit 0.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  32  completion value; valid while `done`=1 and held until the next completion.
- `wr_data`  out  1  pixel bit for the RAM.
- `wr_addr`  out  ADDR_W  RAM write address.
- `wr_en`  out  1  RAM write enable.

## Operation
- States: IDLE, WRITE, CLEAR, FINISH.
- IDLE
  - `start`=1 latches `dataa`, `datab`, and the opcode.
  - Opcode 00 → WRITE.
  - Opcode 01 → CLEAR (if compiled in, see Configuration).
  - Any other opcode → FINISH with error result.
- WRITE: 32 beats. Beat k drives:
  - `wr_en`=1
  - `wr_addr` = (base + k) mod 2**ADDR_W
  - `wr_data` = `datab[k]`
  - After beat 31 → FINISH with `result` = {20'b0, (base+32) mod 4096}, i.e. the next free address.
- CLEAR: 4096 beats. Beat k drives:
  - `wr_en`=1
  - `wr_addr` = k, starting at 0 regardless of base
  - `wr_data` = `datab[0]`
  - After beat 4095 → FINISH with `result` = 32'd4096.
- Error result: 32'hFFFF_FFFF, with no RAM writes.
- FINISH: `done`=1 for exactly one cycle, `wr_en`=0, then → IDLE.
- `start` outside IDLE is ignored. No queuing; the CPU stalls on `done` anyway.
- Address arithmetic is modulo 2**ADDR_W. A WRITE whose base is within 32 of the top wraps to address 0 mid-word.
- Operands are captured at `start`. Later changes on `dataa`/`datab` have no effect.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - `done`=0, `wr_en`=0, `wr_data`=0, `wr_addr`=0
  - `result`=0
  - beat counter 0
- `start` sampled high at cycle 0 (IDLE):
  - WRITE: `wr_en`=1 in cycles 1–32, `done`=1 in cycle 33. Latency 33 cycles.
  - CLEAR: `wr_en`=1 in cycles 1–4096, `done`=1 in cycle 4097.
  - Error opcode: `done`=1 in cycle 1, no `wr_en`.
- `start` and `done` in the same cycle: `start` is ignored, because the state is FINISH, not IDLE. A new instruction is accepted from the cycle after `done`.
- `reset` mid-operation:
  - Next cycle: IDLE, `wr_en`=0, and no `done` for the aborted instruction.
  - RAM words already written stay written.
  - `result` returns to 0.
- `result` changes only in the cycle `done` rises (or on reset).

## Configuration
- `FRAME_CLEAR_EN` defined: opcode 01 performs the full-frame CLEAR described above.
- `FRAME_CLEAR_EN` undefined:
  - The CLEAR state and its 13-bit counter extension are not synthesised.
  - Opcode 01 behaves as reserved: `done` in cycle 1, `result`=32'hFFFF_FFFF, no writes.

## Test plan
- Reset, then idle 10 cycles → `done`=0, `wr_en`=0, `result`=0 throughout.
- WRITE, `dataa`=32'h0000_0040, `datab`=32'hA5A5_0F0F:
  - `wr_en` high exactly cycles 1–32.
  - Addresses 0x040–0x05F; `wr_data` sequence equals `datab` bits 0..31.
  - `done` at cycle 33, `result`=32'h60.
- WRITE with base 0xFF0, `datab`=32'hFFFF_FFFF → addresses 0xFF0–0xFFF then 0x000–0x00F, `result`=32'h10.
- CLEAR (`FRAME_CLEAR_EN` defined), `datab`=1 → 4096 writes of 1 at addresses 0..4095, `done` at cycle 4097, `result`=4096. Build without the macro → `done` at cycle 1, `result`=32'hFFFF_FFFF, zero writes.
- Opcode 11 → `done` at cycle 1, `result`=32'hFFFF_FFFF. Second `start` pulse at cycle 10 of a WRITE → ignored; exactly 32 writes and one `done`.
- `reset` asserted at cycle 15 of a WRITE → `wr_en`=0 from cycle 16, no `done`. A following WRITE completes normally in 33 cycles.
